// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow asynchronous
// input in cycles of clock_undivided. Each accepted measurement is reported
// with a one-cycle period_valid strobe. Intervals shorter than MIN_PERIOD are
// treated as glitches, and a missing edge for TIMEOUT cycles aborts the
// measurement.
module clk_period_meter #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 24,
   parameter int TIMEOUT     = 10000000,
   parameter int MIN_PERIOD  = 4
) (
   input  logic             clock_undivided,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             timeout,
   output logic [15:0]      edge_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sdly_q, sdly_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       hlat_q, hlat_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic                   vld_q, vld_d;
   logic                   to_q, to_d;
   logic [15:0]            ecnt_q, ecnt_d;

   logic                   s;
   logic                   rise;
   logic                   fall;

   // Synchronizer shift and one-cycle delay of the synchronized level for edge detection
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      s      = sync_q[SYNC_STAGES-1];
      sdly_d = s;
      rise   = s & ~sdly_q;
      fall   = ~s & sdly_q;
   end

   // Next-state and measurement datapath; enable low overrides everything, including a rise
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hlat_d   = hlat_q;
      period_d = period_q;
      high_d   = high_q;
      vld_d    = 1'b0;
      to_d     = to_q;
      ecnt_d   = ecnt_q;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         to_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = ARM;
            end
            ARM: begin
               if (rise) begin
                  cnt_d   = ONE_C;
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               // counter equals cycles since the last rise, so it is the high time at a fall
               if (fall) begin
                  hlat_d = cnt_q;
               end
               if (rise) begin
                  if (cnt_q >= MIN_C) begin
                     period_d = cnt_q;
                     high_d   = hlat_q;
                     vld_d    = 1'b1;
                     ecnt_d   = ecnt_q + 16'd1;
                     to_d     = 1'b0;
                  end
                  // a rejected glitch still restarts timing from this edge
                  cnt_d = ONE_C;
               end else if (cnt_q == TIMEOUT_C) begin
                  to_d    = 1'b1;
                  cnt_d   = '0;
                  state_d = ARM;
               end else begin
                  cnt_d = cnt_q + ONE_C;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and data registers with asynchronous clear
   always_ff @(posedge clock_undivided or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sync_q   <= '0;
         sdly_q   <= 1'b0;
         cnt_q    <= '0;
         hlat_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         vld_q    <= 1'b0;
         to_q     <= 1'b0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         sdly_q   <= sdly_d;
         cnt_q    <= cnt_d;
         hlat_q   <= hlat_d;
         period_q <= period_d;
         high_q   <= high_d;
         vld_q    <= vld_d;
         to_q     <= to_d;
         ecnt_q   <= ecnt_d;
      end
   end

   assign period       = period_q;
   assign high_time    = high_q;
   assign period_valid = vld_q;
   assign timeout      = to_q;
   assign edge_count   = ecnt_q;
   assign busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: directed scenarios plus randomized pulse
// trains, checked every cycle against a timestamp-based behavioural model.
module tb_clk_period_meter;
   localparam int SS = 2;
   localparam int CW = 16;
   localparam int TO = 1000;
   localparam int MP = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sig_in = 1'b0;
   logic          enable = 1'b0;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          period_valid;
   logic          timeout;
   logic [15:0]   edge_count;
   logic          busy;

   always #5 clk = ~clk;

   clk_period_meter #(
      .SYNC_STAGES(SS),
      .CNT_W      (CW),
      .TIMEOUT    (TO),
      .MIN_PERIOD (MP)
   ) dut (
      .clock_undivided(clk),
      .reset          (reset),
      .sig_in         (sig_in),
      .enable         (enable),
      .period         (period),
      .high_time      (high_time),
      .period_valid   (period_valid),
      .timeout        (timeout),
      .edge_count     (edge_count),
      .busy           (busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: timestamps of synchronized edges instead of a counter.
   // mode 0 = disabled, 1 = waiting for first rise, 2 = timing from t_rise.
   logic          dl [0:SS];
   int            t;
   int            t_rise;
   int            h_len;
   int            mode;
   logic [CW-1:0] m_per;
   logic [CW-1:0] m_high;
   logic          m_vld;
   logic          m_to;
   logic [15:0]   m_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= SS; i++) dl[i] = 1'b0;
         t = 0; t_rise = 0; h_len = 0; mode = 0;
         m_per = '0; m_high = '0; m_vld = 1'b0; m_to = 1'b0; m_cnt = '0;
      end else begin
         logic ms, msd, mrise, mfall;
         ms    = dl[SS-1];
         msd   = dl[SS];
         mrise = ms && !msd;
         mfall = !ms && msd;
         m_vld = 1'b0;
         if (!enable) begin
            mode = 0;
            m_to = 1'b0;
         end else if (mode == 0) begin
            mode = 1;
         end else if (mode == 1) begin
            if (mrise) begin
               mode   = 2;
               t_rise = t;
            end
         end else begin
            if (mfall) h_len = t - t_rise;
            if (mrise) begin
               if (t - t_rise >= MP) begin
                  m_per  = CW'(t - t_rise);
                  m_high = CW'(h_len);
                  m_vld  = 1'b1;
                  m_cnt  = m_cnt + 16'd1;
                  m_to   = 1'b0;
               end
               t_rise = t;
            end else if (t - t_rise == TO) begin
               m_to = 1'b1;
               mode = 1;
            end
         end
         for (int i = SS; i >= 1; i--) dl[i] = dl[i-1];
         dl[0] = sig_in;
         t++;
      end
   end

   // Per-cycle compare against the model, and record what each strobe carried
   int            strobes = 0;
   logic [CW-1:0] last_p = '0;
   logic [CW-1:0] last_h = '0;
   logic [15:0]   last_ec = '0;

   always @(negedge clk) begin
      if (!reset) begin
         check("period", period, m_per);
         check("high_time", high_time, m_high);
         check("period_valid", period_valid, m_vld);
         check("timeout", timeout, m_to);
         check("edge_count", edge_count, m_cnt);
         check("busy", busy, mode == 2);
         if (period_valid) begin
            strobes++;
            last_p  = period;
            last_h  = high_time;
            last_ec = edge_count;
         end
      end
   end

   task automatic drive(input logic v, input int n);
      sig_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_period"}, period, 0);
      check({tag, "_high"}, high_time, 0);
      check({tag, "_valid"}, period_valid, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_ecount"}, edge_count, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   int s0;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      reset  = 1'b0;
      enable = 1'b1;
      drive(1'b0, 3);

      // Square wave, period 40 / high 20: first rise arms, then one strobe per rise
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 20);
         drive(1'b0, 20);
      end
      check("s1_period", last_p, 40);
      check("s1_high", last_h, 20);
      check("s1_ecount", edge_count, 3);

      // Glitch: rise 2 cycles after an accepted rise, then a clean 20-cycle period
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 10);
      drive(1'b0, 10);
      drive(1'b1, 5);
      check("s2_period", last_p, 20);
      check("s2_high", last_h, 10);
      check("s2_ecount", edge_count, 5);

      // Timeout exactly TO cycles after the last detected rise
      drive(1'b0, 997);
      check("s3_to_early", timeout, 0);
      drive(1'b0, 1);
      check("s3_to_set", timeout, 1);
      check("s3_busy", busy, 0);
      check("s3_period_hold", period, 20);
      drive(1'b0, 100);
      s0 = strobes;
      drive(1'b1, 25);
      check("s3_first_rise_no_strobe", strobes, s0);
      check("s3_to_still", timeout, 1);
      drive(1'b0, 25);
      drive(1'b1, 25);
      check("s3_period50", last_p, 50);
      check("s3_high25", last_h, 25);
      check("s3_to_clear", timeout, 0);
      drive(1'b0, 25);

      // Enable drop coinciding with a rise
      s0 = strobes;
      enable = 1'b0;
      drive(1'b1, 5);
      enable = 1'b1;
      drive(1'b1, 20);
      drive(1'b0, 25);
      drive(1'b1, 25);
      check("s4_no_strobe", strobes, s0);
      drive(1'b0, 25);
      drive(1'b1, 25);
      check("s4_one_strobe", strobes, s0 + 1);
      check("s4_period", last_p, 50);
      drive(1'b0, 10);

      // Randomized pulse trains with occasional long gaps and enable drops
      for (int i = 0; i < 250; i++) begin
         int hi, lo;
         hi = $urandom_range(1, 40);
         lo = ($urandom_range(0, 19) == 0) ? $urandom_range(900, 1100) : $urandom_range(1, 40);
         if ($urandom_range(0, 24) == 0) begin
            enable = 1'b0;
            drive(sig_in, $urandom_range(1, 6));
            enable = 1'b1;
         end
         drive(1'b1, hi);
         drive(1'b0, lo);
      end

      // Asynchronous reset mid-period
      drive(1'b1, 15);
      drive(1'b0, 15);
      drive(1'b1, 15);
      drive(1'b0, 5);
      check("s5_busy_before", busy, 1);
      #2 reset = 1'b1;
      #1 check_all_zero("s5_async");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 10);
      check("s5_idle_busy", busy, 0);
      s0 = strobes;
      drive(1'b1, 15);
      drive(1'b0, 15);
      check("s5_first_rise_no_strobe", strobes, s0);
      drive(1'b1, 15);
      check("s5_ecount", edge_count, 1);
      check("s5_period", last_p, 30);

      // edge_count wrap from 65535
      #2 force dut.ecnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1 release dut.ecnt_q;
      @(negedge clk);
      drive(1'b0, 14);
      drive(1'b1, 10);
      check("s6_wrap_ecount", edge_count, 0);
      check("s6_wrap_strobe_ec", last_ec, 0);
      drive(1'b0, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
